// File: rtl/jtag_tap_seq.sv
// JTAG master sequencer: turns TAP-reset / IR-scan / DR-scan commands into TCK/TMS/TDI waveforms.
// Optional macro JTAG_TAP_SEQ_AUTO_RESET_EN runs a TAP reset by itself after rst deasserts.
module jtag_tap_seq #(
   parameter int TCK_DIV      = 5,
   parameter int RESET_CYCLES = 8,
   parameter int MAX_LEN      = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [5:0]  cmd_len,
   input  logic [39:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [39:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic        jtag_TCK,
   output logic        jtag_TMS,
   output logic        jtag_TDI,
   input  logic        jtag_TDO
);

   typedef enum logic [3:0] {
      IDLE, RST_SEQ, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, DONE
   } state_t;

   localparam logic [15:0] LOW_END  = 16'(TCK_DIV - 1);
   localparam logic [15:0] PER_END  = 16'(2 * TCK_DIV - 1);
   localparam logic [7:0]  RST_LAST = 8'(RESET_CYCLES);

   state_t      state;
   logic [15:0] cnt;
   logic [7:0]  ecnt;
   logic [5:0]  bit_idx;
   logic [5:0]  len;
   logic [39:0] data;
   logic        is_ir;
   logic        auto_pend;
   logic        auto_run;
   logic        len_bad;

   always_comb begin
      len_bad = (cmd_len == 6'd0) || (int'(cmd_len) > MAX_LEN);
   end

   // cnt walks one TCK period: low half then high half; edges advance at period end.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ecnt      <= '0;
         bit_idx   <= '0;
         len       <= '0;
         data      <= '0;
         is_ir     <= 1'b0;
         auto_run  <= 1'b0;
`ifdef JTAG_TAP_SEQ_AUTO_RESET_EN
         auto_pend <= 1'b1;
         cmd_ready <= 1'b0;
`else
         auto_pend <= 1'b0;
         cmd_ready <= 1'b1;
`endif
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         jtag_TCK  <= 1'b0;
         jtag_TMS  <= 1'b1;
         jtag_TDI  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (auto_pend) begin
                  auto_pend <= 1'b0;
                  auto_run  <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= RST_SEQ;
                  ecnt      <= '0;
                  cnt       <= '0;
                  jtag_TMS  <= 1'b1;
               end else if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b0;
                  len       <= cmd_len;
                  data      <= cmd_data;
                  is_ir     <= (cmd_type == 2'd1);
                  cnt       <= '0;
                  ecnt      <= '0;
                  if (cmd_type == 2'd0) begin
                     state    <= RST_SEQ;
                     busy     <= 1'b1;
                     jtag_TMS <= 1'b1;
                  end else if (cmd_type == 2'd3 || len_bad) begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state    <= SEL_DR;
                     busy     <= 1'b1;
                     jtag_TMS <= 1'b1;
                  end
               end
            end

            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               if (cnt == LOW_END) begin
                  jtag_TCK <= 1'b1;
                  if (state == SHIFT)
                     rsp_data[bit_idx] <= jtag_TDO;
               end
               if (cnt != PER_END) begin
                  cnt <= cnt + 16'd1;
               end else begin
                  cnt      <= '0;
                  jtag_TCK <= 1'b0;
                  case (state)
                     RST_SEQ: begin
                        if (ecnt == RST_LAST) begin
                           jtag_TMS <= 1'b0;
                           busy     <= 1'b0;
                           if (auto_run) begin
                              auto_run  <= 1'b0;
                              cmd_ready <= 1'b1;
                              state     <= IDLE;
                           end else begin
                              rsp_valid <= 1'b1;
                              state     <= DONE;
                           end
                        end else begin
                           ecnt     <= ecnt + 8'd1;
                           jtag_TMS <= (ecnt != RST_LAST - 8'd1);
                        end
                     end
                     SEL_DR: begin
                        jtag_TMS <= is_ir;
                        ecnt     <= '0;
                        state    <= is_ir ? SEL_IR : CAPTURE;
                     end
                     SEL_IR: begin
                        jtag_TMS <= 1'b0;
                        ecnt     <= '0;
                        state    <= CAPTURE;
                     end
                     // Two TMS=0 edges here: enter Capture, then Capture->Shift.
                     CAPTURE: begin
                        if (ecnt == 8'd0) begin
                           ecnt     <= 8'd1;
                           jtag_TMS <= 1'b0;
                        end else begin
                           state    <= SHIFT;
                           bit_idx  <= '0;
                           jtag_TMS <= (len == 6'd1);
                           jtag_TDI <= data[0];
                        end
                     end
                     SHIFT: begin
                        if (bit_idx == len - 6'd1) begin
                           state    <= EXIT1;
                           jtag_TMS <= 1'b1;
                        end else begin
                           bit_idx  <= bit_idx + 6'd1;
                           jtag_TMS <= (bit_idx + 6'd1 == len - 6'd1);
                           jtag_TDI <= data[bit_idx + 6'd1];
                        end
                     end
                     EXIT1: begin
                        state    <= UPDATE;
                        jtag_TMS <= 1'b0;
                     end
                     UPDATE: begin
                        state     <= DONE;
                        jtag_TMS  <= 1'b0;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_tap_seq.sv
// Directed bench for jtag_tap_seq with a behavioural TAP (IR capture 5'b00001, DR capture DR_CAP).
module tb_jtag_tap_seq;

   localparam int          DIV    = 2;
   localparam logic [39:0] DR_CAP = 40'h12_3456_789A;

   typedef enum int {
      TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
      SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
   } tap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_type = 2'd0;
   logic [5:0]  cmd_len = 6'd0;
   logic [39:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [39:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic        jtag_TCK;
   logic        jtag_TMS;
   logic        jtag_TDI;
   logic        tdo = 1'b0;

   int total = 0;
   int bad   = 0;

   jtag_tap_seq #(.TCK_DIV(DIV), .RESET_CYCLES(8), .MAX_LEN(40)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy),
      .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(tdo)
   );

   always #5 clk = ~clk;

   // Behavioural TAP: standard 16-state controller plus IR/DR shift registers.
   tap_t        tap_state = SHDR;
   logic [4:0]  ir_sr = '0;
   logic [4:0]  ir_reg = '0;
   logic [39:0] dr_sr = '0;
   logic [39:0] dr_upd = '0;
   int          tck_edges = 0;
   int          shift_edges = 0;
   logic [63:0] tms_log = '0;
   logic [63:0] tdi_hist = '0;

   function automatic tap_t tapNext(input tap_t s, input logic tms);
      case (s)
         TLR:  return tms ? TLR  : RTI;
         RTI:  return tms ? SDR  : RTI;
         SDR:  return tms ? SIR  : CDR;
         CDR:  return tms ? E1DR : SHDR;
         SHDR: return tms ? E1DR : SHDR;
         E1DR: return tms ? UDR  : PDR;
         PDR:  return tms ? E2DR : PDR;
         E2DR: return tms ? UDR  : SHDR;
         UDR:  return tms ? SDR  : RTI;
         SIR:  return tms ? TLR  : CIR;
         CIR:  return tms ? E1IR : SHIR;
         SHIR: return tms ? E1IR : SHIR;
         E1IR: return tms ? UIR  : PIR;
         PIR:  return tms ? E2IR : PIR;
         E2IR: return tms ? UIR  : SHIR;
         default: return tms ? SDR : RTI;
      endcase
   endfunction

   always @(posedge jtag_TCK) begin
      tck_edges = tck_edges + 1;
      tms_log   = {tms_log[62:0], jtag_TMS};
      case (tap_state)
         CIR:  ir_sr = 5'b00001;
         SHIR: begin
            ir_sr       = {jtag_TDI, ir_sr[4:1]};
            tdi_hist    = {jtag_TDI, tdi_hist[63:1]};
            shift_edges = shift_edges + 1;
         end
         UIR:  ir_reg = ir_sr;
         CDR:  dr_sr = DR_CAP;
         SHDR: begin
            dr_sr       = {jtag_TDI, dr_sr[39:1]};
            tdi_hist    = {jtag_TDI, tdi_hist[63:1]};
            shift_edges = shift_edges + 1;
         end
         UDR:  dr_upd = dr_sr;
         default: ;
      endcase
      tap_state = tapNext(tap_state, jtag_TMS);
   end

   always @(negedge jtag_TCK) begin
      tdo <= (tap_state == SHIR) ? ir_sr[0] : (tap_state == SHDR) ? dr_sr[0] : 1'b0;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command; returns clocks from accept until rsp_valid is sampled high.
   task automatic applyStimulus(input logic [1:0] t, input logic [5:0] l, input logic [39:0] d,
                                output int lat, output logic busy_first);
      int w;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      checkOutput("ready_wait_timeout", 64'(w < 100), 64'd1);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_len   = l;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid  = 1'b0;
      busy_first = busy;
      lat = 1;
      while (!rsp_valid && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int   lat;
      int   e0;
      int   s0;
      int   glitches;
      logic bf;

      // reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
      checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI}), 64'b011);
      rst = 1'b0;

      // TAP reset: 9 edges, TMS 1x8 then 0, latency 9*2*DIV+1
      e0 = tck_edges;
      applyStimulus(2'd0, 6'd0, 40'd0, lat, bf);
      checkOutput("tapreset_busy", 64'(bf), 64'd1);
      checkOutput("tapreset_latency", 64'(lat), 64'd37);
      checkOutput("tapreset_edges", 64'(tck_edges - e0), 64'd9);
      checkOutput("tapreset_tms", 64'(tms_log[8:0]), 64'b111111110);
      checkOutput("tapreset_err", 64'(rsp_err), 64'd0);
      checkOutput("tapreset_state", 64'(tap_state), 64'(RTI));
      checkOutput("tapreset_idle_pins", 64'({jtag_TCK, jtag_TMS, busy}), 64'd0);
      consume();
      checkOutput("tapreset_ready_after", 64'(cmd_ready), 64'd1);

      // IR scan len 5, data 0x11
      e0 = tck_edges;
      applyStimulus(2'd1, 6'd5, 40'h11, lat, bf);
      checkOutput("ir_latency", 64'(lat), 64'd45);
      checkOutput("ir_edges", 64'(tck_edges - e0), 64'd11);
      checkOutput("ir_tms", 64'(tms_log[10:0]), 64'b11000000110);
      checkOutput("ir_tdi", 64'(tdi_hist[63:59]), 64'h11);
      checkOutput("ir_reg", 64'(ir_reg), 64'h11);
      checkOutput("ir_rsp_data", 64'(rsp_data), 64'h1);
      checkOutput("ir_state", 64'(tap_state), 64'(RTI));
      consume();

      // DR scan len 40, then hold the response for 100 clocks
      e0 = tck_edges;
      applyStimulus(2'd2, 6'd40, 40'h40_0000_0002, lat, bf);
      checkOutput("dr40_latency", 64'(lat), 64'd181);
      checkOutput("dr40_edges", 64'(tck_edges - e0), 64'd45);
      checkOutput("dr40_update", 64'(dr_upd), 64'h40_0000_0002);
      checkOutput("dr40_rsp_data", 64'(rsp_data), 64'(DR_CAP));
      checkOutput("dr40_err", 64'(rsp_err), 64'd0);
      glitches = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || jtag_TCK !== 1'b0 ||
             jtag_TMS !== 1'b0 || rsp_data !== DR_CAP)
            glitches++;
      end
      checkOutput("hold_stable", 64'(glitches), 64'd0);
      checkOutput("hold_no_edges", 64'(tck_edges - e0), 64'd45);
      consume();
      checkOutput("hold_release_ready", 64'(cmd_ready), 64'd1);
      checkOutput("hold_release_valid", 64'(rsp_valid), 64'd0);

      // Short DR scan: upper response bits must be zero
      applyStimulus(2'd2, 6'd8, 40'hC3, lat, bf);
      checkOutput("dr8_latency", 64'(lat), 64'd53);
      checkOutput("dr8_tdi", 64'(tdi_hist[63:56]), 64'hC3);
      checkOutput("dr8_rsp_data", 64'(rsp_data), 64'h9A);
      consume();

      // Illegal commands: no pin activity, immediate error response
      e0 = tck_edges;
      applyStimulus(2'd2, 6'd0, 40'hFF, lat, bf);
      checkOutput("len0_latency", 64'(lat), 64'd1);
      checkOutput("len0_err", 64'(rsp_err), 64'd1);
      checkOutput("len0_data", 64'(rsp_data), 64'd0);
      checkOutput("len0_edges", 64'(tck_edges - e0), 64'd0);
      consume();
      applyStimulus(2'd1, 6'd41, 40'hFF, lat, bf);
      checkOutput("len41_latency", 64'(lat), 64'd1);
      checkOutput("len41_err", 64'(rsp_err), 64'd1);
      checkOutput("len41_edges", 64'(tck_edges - e0), 64'd0);
      consume();
      applyStimulus(2'd3, 6'd5, 40'hFF, lat, bf);
      checkOutput("type3_latency", 64'(lat), 64'd1);
      checkOutput("type3_err", 64'(rsp_err), 64'd1);
      checkOutput("type3_pins", 64'({jtag_TCK, tck_edges - e0 == 0}), 64'b01);
      consume();

      // rst in the middle of a 40-bit DR scan
      s0 = shift_edges;
      applyStimulus(2'd2, 6'd40, 40'hAB_CDEF_0123, lat, bf);
      consume();
      s0 = shift_edges;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_type  = 2'd2;
      cmd_len   = 6'd40;
      cmd_data  = 40'hFF_FFFF_FFFF;
      @(negedge clk);
      cmd_valid = 1'b0;
      glitches = 0;
      while (shift_edges - s0 < 20 && glitches < 2000) begin
         @(negedge clk);
         glitches++;
      end
      checkOutput("midrst_reach_bit20", 64'(glitches < 2000), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI}), 64'b011);
      checkOutput("midrst_rsp_busy", 64'({rsp_valid, busy}), 64'd0);
      checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'd0);

      // Recover the TAP
      applyStimulus(2'd0, 6'd0, 40'd0, lat, bf);
      checkOutput("recover_latency", 64'(lat), 64'd37);
      checkOutput("recover_state", 64'(tap_state), 64'(RTI));
      consume();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
